// File: rtl/fc_seq_pkg.sv
// fc_seq_pkg: state encoding and sizing helpers shared by the fc layer sequencer files.
package fc_seq_pkg;
  typedef enum logic [1:0] {LOAD, SETTLE, DRAIN} state_t;
  localparam int SETTLE_MAX = 255;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fc_drain_argmax.sv
// fc_drain_argmax: selects the snapshot entry being drained; with FC_SEQ_ARGMAX_EN it also
// tracks the running max over drained beats and reports the winning neuron index.
module fc_drain_argmax
  import fc_seq_pkg::*;
#(
  parameter int NEURONS = 120,
  parameter int ZW = 25,
  parameter int IW = $clog2(NEURONS)
) (
`ifdef FC_SEQ_ARGMAX_EN
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic fire,
  input  logic last,
  output logic class_valid,
  output logic [IW-1:0] class_idx,
`endif
  input  logic [NEURONS*ZW-1:0] snapshot,
  input  logic [IW-1:0] idx,
  output logic [ZW-1:0] data
);
  always_comb data = snapshot[idx*ZW +: ZW];
`ifdef FC_SEQ_ARGMAX_EN
  logic [ZW-1:0] max_v;
  logic [IW-1:0] max_i;
  logic gt;
  // strict compare keeps the lowest index on ties
  always_comb gt = data > max_v;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_v <= '0;
      max_i <= '0;
      class_valid <= 1'b0;
      class_idx <= '0;
    end else begin
      class_valid <= fire && last;
      if (start) begin
        max_v <= '0;
        max_i <= '0;
      end else if (fire && gt) begin
        max_v <= data;
        max_i <= idx;
      end
      if (fire && last) class_idx <= gt ? idx : max_i;
    end
  end
`endif
endmodule

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: loads a serial activation frame, holds it for SETTLE cycles, snapshots the
// neuron bank and drains it one result per valid/ready beat. FC_SEQ_ARGMAX_EN adds class outputs.
module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IN = 400,
  parameter int NEURONS = 120,
  parameter int ZW = 2*WIDTH+9,
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [IN*WIDTH-1:0] x_vec,
  input  logic [NEURONS*ZW-1:0] z_vec,
  output logic out_valid,
  input  logic out_ready,
  output logic [ZW-1:0] out_data,
  output logic [$clog2(NEURONS)-1:0] out_idx,
  output logic out_last,
`ifdef FC_SEQ_ARGMAX_EN
  output logic class_valid,
  output logic [$clog2(NEURONS)-1:0] class_idx,
`endif
  output logic busy
);
  localparam int IW = $clog2(NEURONS);
  localparam int LW = clog2(IN);
  localparam int SW = clog2(SETTLE_MAX + 1);
  localparam logic [LW-1:0] LD_LAST = LW'(IN - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(SETTLE - 1);
  localparam logic [IW-1:0] DR_LAST = IW'(NEURONS - 1);

  state_t state, state_n;
  logic [LW-1:0] ld_cnt;
  logic [SW-1:0] st_cnt;
  logic [IW-1:0] dr_cnt;
  logic [NEURONS*ZW-1:0] snapshot;
  logic in_fire, out_fire, snap;

  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign snap = state == fc_seq_pkg::SETTLE && st_cnt == ST_LAST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= fc_seq_pkg::LOAD;
    else state <= state_n;
  end

  always_comb
    state_n = state == fc_seq_pkg::LOAD ? (in_fire && ld_cnt == LD_LAST ? fc_seq_pkg::SETTLE : fc_seq_pkg::LOAD)
            : state == fc_seq_pkg::SETTLE ? (snap ? fc_seq_pkg::DRAIN : fc_seq_pkg::SETTLE)
            : (out_fire && out_last ? fc_seq_pkg::LOAD : fc_seq_pkg::DRAIN);

  always_comb begin
    in_ready = state == fc_seq_pkg::LOAD;
    out_valid = state == fc_seq_pkg::DRAIN;
    out_idx = dr_cnt;
    out_last = out_valid && dr_cnt == DR_LAST;
    busy = state != fc_seq_pkg::LOAD || ld_cnt != '0;
  end

  // x_vec only changes in LOAD, giving the neuron bank a SETTLE-cycle path to the snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt <= '0;
      st_cnt <= '0;
      dr_cnt <= '0;
      x_vec <= '0;
      snapshot <= '0;
    end else begin
      if (in_fire) begin
        x_vec[ld_cnt*WIDTH +: WIDTH] <= in_data;
        ld_cnt <= ld_cnt == LD_LAST ? '0 : ld_cnt + 1'b1;
      end
      if (state == fc_seq_pkg::SETTLE) st_cnt <= snap ? '0 : st_cnt + 1'b1;
      if (snap) snapshot <= z_vec;
      if (out_fire) dr_cnt <= dr_cnt == DR_LAST ? '0 : dr_cnt + 1'b1;
    end
  end

  fc_drain_argmax #(.NEURONS(NEURONS), .ZW(ZW), .IW(IW)) u_drain (
`ifdef FC_SEQ_ARGMAX_EN
    .clk(clk),
    .rst(rst),
    .start(snap),
    .fire(out_fire),
    .last(out_last),
    .class_valid(class_valid),
    .class_idx(class_idx),
`endif
    .snapshot(snapshot),
    .idx(dr_cnt),
    .data(out_data)
  );
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer: scoreboard bench with a behavioural neuron bank (WIDTH=8, IN=4, NEURONS=3, SETTLE=2).
module tb_fc_layer_sequencer;
  localparam int WIDTH = 8, IN = 4, NEURONS = 3, ZW = 18, SETTLE = 2, IW = 2;
  typedef struct {
    logic [IW-1:0] idx;
    logic [ZW-1:0] data;
    logic last;
    logic [IW-1:0] cls;
  } exp_t;

  logic clk = 0, rst = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_last, busy;
  logic [WIDTH-1:0] in_data = '0;
  logic [IN*WIDTH-1:0] x_vec;
  logic [NEURONS*ZW-1:0] z_vec;
  logic [ZW-1:0] out_data;
  logic [IW-1:0] out_idx;
`ifdef FC_SEQ_ARGMAX_EN
  logic class_valid;
  logic [IW-1:0] class_idx;
`endif

  int w[NEURONS][IN];
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0, t_in = 0, n_acc = 0;
  bit acc = 0, seen_first = 0, chk_lat = 0, cls_due = 0;
  logic [IW-1:0] cls_exp = '0;

  fc_layer_sequencer #(.WIDTH(WIDTH), .IN(IN), .NEURONS(NEURONS), .ZW(ZW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .x_vec(x_vec), .z_vec(z_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
`ifdef FC_SEQ_ARGMAX_EN
    .class_valid(class_valid), .class_idx(class_idx),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [ZW-1:0] zf(input int k, input logic [IN*WIDTH-1:0] xv);
    int s = 0;
    for (int i = 0; i < IN; i++) s += w[k][i] * int'(xv[i*WIDTH +: WIDTH]);
    return s < 0 ? '0 : ZW'(s);
  endfunction

  always_comb begin
    z_vec = '0;
    for (int k = 0; k < NEURONS; k++) z_vec[k*ZW +: ZW] = zf(k, x_vec);
  end

  task automatic push_frame(input int xs[IN]);
    logic [IN*WIDTH-1:0] xv;
    logic [ZW-1:0] mx;
    logic [IW-1:0] ci;
    exp_t e;
    for (int i = 0; i < IN; i++) xv[i*WIDTH +: WIDTH] = WIDTH'(xs[i]);
    mx = '0;
    ci = '0;
    for (int k = 0; k < NEURONS; k++) if (zf(k, xv) > mx) begin mx = zf(k, xv); ci = IW'(k); end
    for (int k = 0; k < NEURONS; k++) begin
      e.idx = IW'(k);
      e.data = zf(k, xv);
      e.last = (k == NEURONS - 1);
      e.cls = ci;
      q.push_back(e);
    end
  endtask

  task automatic mon();
    exp_t e;
    acc = in_valid && in_ready;
    if (acc) begin n_acc++; t_in = cyc; end
`ifdef FC_SEQ_ARGMAX_EN
    if (cls_due || class_valid) begin
      checks++;
      assert (class_valid === cls_due && class_idx === cls_exp) else begin
        failures++;
        $error("FAIL class obs valid=%0b idx=%0d exp valid=%0b idx=%0d", class_valid, class_idx, cls_due, cls_exp);
      end
    end
    cls_due = 0;
`endif
    if (out_valid) begin
      checks++;
      assert (in_ready === 1'b0) else begin failures++; $error("FAIL in_ready_in_drain obs=%0b exp=0", in_ready); end
      if (!seen_first) begin
        seen_first = 1;
        if (chk_lat) begin
          checks++;
          assert (cyc - t_in == SETTLE + 1) else begin failures++; $error("FAIL first_latency obs=%0d exp=%0d", cyc - t_in, SETTLE + 1); end
        end
      end
    end
    if (out_valid && out_ready) begin
      checks++;
      assert (q.size() > 0) else begin failures++; $error("FAIL unexpected_beat idx=%0d data=%0d", out_idx, out_data); end
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        assert ({out_idx, out_data, out_last} === {e.idx, e.data, e.last}) else begin
          failures++;
          $error("FAIL beat obs idx=%0d data=%0d last=%0b exp idx=%0d data=%0d last=%0b", out_idx, out_data, out_last, e.idx, e.data, e.last);
        end
        if (e.last) begin seen_first = 0; cls_due = 1; cls_exp = e.cls; end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic feed(input int xs[8], input int n);
    int j = 0, b = 0;
    while (j < n && b < 200) begin
      in_valid = 1;
      in_data = WIDTH'(xs[j]);
      tick();
      b++;
      if (acc) j++;
    end
    in_valid = 0;
    checks++;
    assert (j == n) else begin failures++; $error("FAIL feed_accepted obs=%0d exp=%0d", j, n); end
  endtask

  task automatic drain(input int hold_idx, input int hold_len, input int stop_idx);
    int held = 0, b = 0;
    bit done = 0;
    while (!done && b < 300) begin
      if (q.size() == 0 && in_ready && !out_valid) done = 1;
      else if (stop_idx >= 0 && out_valid && out_idx == IW'(stop_idx)) done = 1;
      else begin
        out_ready = !(out_valid && out_idx == IW'(hold_idx) && held < hold_len);
        if (!out_ready) begin
          held++;
          checks++;
          assert ({out_valid, in_ready, out_idx, out_data} === {1'b1, 1'b0, IW'(hold_idx), (q.size() > 0 ? q[0].data : '0)}) else begin
            failures++;
            $error("FAIL hold_stable obs valid=%0b rdy=%0b idx=%0d data=%0d exp idx=%0d", out_valid, in_ready, out_idx, out_data, hold_idx);
          end
        end
        tick();
        b++;
      end
    end
    out_ready = 1;
    checks++;
    assert (done) else begin failures++; $error("FAIL drain_timeout obs=%0d beats_left exp=0", q.size()); end
  endtask

  initial begin
    w = '{'{1, 2, 0, 0}, '{0, -1, 0, 0}, '{3, 0, 0, 1}};
    #1 rst = 1;
    #1;
    checks++;
    assert ({in_ready, out_valid, out_data, out_idx, out_last, busy, x_vec} === {1'b1, 1'b0, {ZW{1'b0}}, {IW{1'b0}}, 1'b0, 1'b0, {IN*WIDTH{1'b0}}}) else begin
      failures++;
      $error("FAIL reset_state obs rdy=%0b valid=%0b data=%0d idx=%0d last=%0b busy=%0b exp 1 0 0 0 0 0", in_ready, out_valid, out_data, out_idx, out_last, busy);
    end
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    // frame 5,6,7,8 with open drain and latency checks
    push_frame('{5, 6, 7, 8});
    chk_lat = 1;
    feed('{5, 6, 7, 8, 0, 0, 0, 0}, 4);
    checks++;
    assert (busy === 1'b1) else begin failures++; $error("FAIL busy_settle obs=%0b exp=1", busy); end
    drain(-1, 0, -1);
    chk_lat = 0;
    checks++;
    assert (cyc - t_in == SETTLE + NEURONS + 1) else begin failures++; $error("FAIL ready_return obs=%0d exp=%0d", cyc - t_in, SETTLE + NEURONS + 1); end
    checks++;
    assert (busy === 1'b0) else begin failures++; $error("FAIL busy_idle obs=%0b exp=0", busy); end
    // back-pressure on beat 1
    push_frame('{5, 6, 7, 8});
    feed('{5, 6, 7, 8, 0, 0, 0, 0}, 4);
    drain(1, 10, -1);
    // continuous in_valid across two frames
    push_frame('{1, 2, 3, 4});
    push_frame('{5, 6, 7, 8});
    n_acc = 0;
    feed('{1, 2, 3, 4, 5, 6, 7, 8}, 8);
    drain(-1, 0, -1);
    checks++;
    assert (n_acc == 8) else begin failures++; $error("FAIL accepted_total obs=%0d exp=8", n_acc); end
    // asynchronous reset mid-drain
    push_frame('{5, 6, 7, 8});
    feed('{5, 6, 7, 8, 0, 0, 0, 0}, 4);
    drain(-1, 0, 1);
    #2 rst = 1;
    #1;
    checks++;
    assert ({out_valid, in_ready} === 2'b01) else begin failures++; $error("FAIL async_reset obs valid=%0b rdy=%0b exp valid=0 rdy=1", out_valid, in_ready); end
    q.delete();
    seen_first = 0;
    cls_due = 0;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    assert ({busy, out_idx, out_data} === {1'b0, {IW{1'b0}}, {ZW{1'b0}}}) else begin
      failures++;
      $error("FAIL post_reset obs busy=%0b idx=%0d data=%0d exp 0 0 0", busy, out_idx, out_data);
    end
    push_frame('{1, 1, 1, 1});
    feed('{1, 1, 1, 1, 0, 0, 0, 0}, 4);
    drain(-1, 0, -1);
    // tie between neurons 0 and 1
    w = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 0, 0}};
    push_frame('{9, 9, 0, 0});
    feed('{9, 9, 0, 0, 0, 0, 0, 0}, 4);
    drain(-1, 0, -1);
    tick();
    checks++;
    assert (q.size() == 0) else begin failures++; $error("FAIL leftover_beats obs=%0d exp=0", q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
